// File: rtl/edge_evt_pkg.sv
// Shared types and sizing helpers for the edge event queue.
package edge_evt_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      LOCKOUT = 1'b1
   } state_t;

   // Width of a down-counter that must hold values 0..lockout.
   function automatic int timer_w(input int lockout);
      return $clog2(lockout + 1);
   endfunction

endpackage

// File: rtl/lockout_timer.sv
// Holdoff down-counter: load arms it to LOCKOUT_CYC-1, counts down to zero, done when zero.
// Latency: load/clr take effect on the next clock; no backpressure.
module lockout_timer
   import edge_evt_pkg::*;
#(
   parameter int LOCKOUT_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clr,
   output logic done
);

   localparam int TW = timer_w(LOCKOUT_CYC);
   localparam logic [TW-1:0] LOAD_VAL = TW'(LOCKOUT_CYC - 1);
   localparam logic [TW-1:0] ONE      = TW'(1);

   logic [TW-1:0] timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (clr) begin
         timer <= '0;
      end else if (load) begin
         timer <= LOAD_VAL;
      end else if (timer != '0) begin
         timer <= timer - ONE;
      end
   end

   assign done = (timer == '0);

endmodule

// File: rtl/edge_event_queue.sv
// Debounces rise pulses with a lockout window, counts accepted edges, and queues them for a consumer.
// Latency: accept/consume visible one cycle later; consumer backpressure via evt_ready, drops set sticky overflow.
module edge_event_queue
   import edge_evt_pkg::*;
#(
   parameter int LOCKOUT_CYC = 4,
   parameter int PEND_MAX    = 3,
   parameter int CNT_W       = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          edge_in,
   input  logic                          clr,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [$clog2(PEND_MAX+1)-1:0] pend_cnt,
   output logic [CNT_W-1:0]              evt_count,
   output logic                          overflow
);

   localparam int PW = $clog2(PEND_MAX + 1);
   localparam logic [PW-1:0]    PEND_FULL = PW'(PEND_MAX);
   localparam logic [PW-1:0]    PEND_ONE  = PW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t        state, state_nxt;
   logic          accept;
   logic          take;
   logic          timer_done;
   logic [PW-1:0] pend_nxt;
   logic          drop;

   lockout_timer #(
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .clr   (clr),
      .done  (timer_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (edge_in) state_nxt = LOCKOUT;
            LOCKOUT: if (timer_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      accept = 1'b0;
      if (state == IDLE && edge_in && !clr) begin
         accept = 1'b1;
      end
   end

   assign take = evt_valid & evt_ready & ~clr;

   // A consume in the same cycle frees the slot, so a full queue only drops without one.
   always_comb begin
      pend_nxt = pend_cnt;
      drop     = 1'b0;
      if (accept && !take) begin
         if (pend_cnt == PEND_FULL) begin
            drop = 1'b1;
         end else begin
            pend_nxt = pend_cnt + PEND_ONE;
         end
      end else if (!accept && take) begin
         pend_nxt = pend_cnt - PEND_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_cnt  <= '0;
         evt_valid <= 1'b0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else if (clr) begin
         pend_cnt  <= '0;
         evt_valid <= 1'b0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         pend_cnt  <= pend_nxt;
         evt_valid <= (pend_nxt != '0);
         if (accept) evt_count <= evt_count + CNT_ONE;
         if (drop)   overflow  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_edge_event_queue.sv
// Directed bench for edge_event_queue at default parameters (LOCKOUT_CYC=4, PEND_MAX=3, CNT_W=8).
module tb_edge_event_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       edge_in;
   logic       clr;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] pend_cnt;
   logic [7:0] evt_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   edge_event_queue #(
      .LOCKOUT_CYC (4),
      .PEND_MAX    (3),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .edge_in   (edge_in),
      .clr       (clr),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .pend_cnt  (pend_cnt),
      .evt_count (evt_count),
      .overflow  (overflow)
   );

   typedef struct {
      logic       e;
      logic       r;
      logic       c;
      logic       valid;
      logic [1:0] pend;
      logic [7:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic v, input int p,
                            input int c, input logic o);
      check({name, ".evt_valid"}, int'(evt_valid), int'(v));
      check({name, ".pend_cnt"},  int'(pend_cnt),  p);
      check({name, ".evt_count"}, int'(evt_count), c);
      check({name, ".overflow"},  int'(overflow),  int'(o));
   endtask

   // Drive inputs away from the active edge, then sample just after it.
   task automatic cyc(input logic e, input logic r, input logic c);
      @(negedge clk);
      edge_in   = e;
      evt_ready = r;
      clr       = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(1'b0, r, 1'b0);
   endtask

   initial begin
      // {edge, ready, clr} -> {valid, pend, count, overflow} after that cycle
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd2, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd2, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd2, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd2, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd3, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd3, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0};

      rst_n = 1'b0;
      edge_in = 1'b0;
      evt_ready = 1'b0;
      clr = 1'b0;
      #23;
      check_all("reset", 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         cyc(vecs[i].e, vecs[i].r, vecs[i].c);
         check_all($sformatf("vec%0d", i), vecs[i].valid, int'(vecs[i].pend),
                   int'(vecs[i].cnt), vecs[i].ovf);
      end

      // Lockout boundary: pulses at relative cycles 0, 2, 4, 5.
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check_all("lockout_bound", 1'b1, 2, 2, 1'b0);

      // Handshake: valid held without ready, one-cycle ready drains it.
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         check($sformatf("hold_valid%0d", i), int'(evt_valid), 1);
      end
      cyc(1'b0, 1'b1, 1'b0);
      check_all("handshake", 1'b0, 0, 1, 1'b0);

      // Overflow: four accepts into a three-deep queue.
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         idle(5, 1'b0);
      end
      check_all("overflow_drop", 1'b1, 3, 4, 1'b1);

      // Same, but the fourth accept coincides with a consume.
      cyc(1'b0, 1'b0, 1'b1);
      check_all("clr_after_ovf", 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         idle(5, 1'b0);
      end
      cyc(1'b1, 1'b1, 1'b0);
      check_all("full_accept_take", 1'b1, 3, 4, 1'b0);

      // Simultaneous accept and consume at pend_cnt=1.
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      idle(5, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      check_all("accept_take", 1'b1, 1, 2, 1'b0);

      // Counter wrap.
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 255; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         idle(5, 1'b1);
      end
      check_all("preload255", 1'b0, 0, 255, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check_all("wrap", 1'b1, 1, 0, 1'b0);
      idle(5, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      check_all("clr_with_edge", 1'b0, 0, 0, 1'b0);

      // Async reset two cycles into a lockout.
      cyc(1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
      check_all("pre_reset", 1'b1, 1, 1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check_all("post_reset_edge", 1'b1, 1, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
